weight_delta_generator: RTL and testbench

//  Consumes the per-neuron delta vector from the error stage and the previous layer's activations.

---
 rtl/backprop_pkg.sv | 38 +++
 rtl/delta_row_mult.sv | 67 ++++++
 rtl/weight_delta_generator.sv | 200 ++++++++++++++++++++
 tb/tb_weight_delta_generator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backprop_pkg.sv
// Shared definitions for the backprop datapath: FSM state encoding, width
// helpers and saturation limits.
//   Optional feature macro used by the consumers of this package:
//   WEIGHT_DELTA_SATURATE_EN (clamp overflowing cells instead of wrapping).
package backprop_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_EMIT = 2'd2;

   // Ceiling log2, never below 1 so that a single-entry index still has a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((64'd1 << k) < 64'(n)) r = k + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // Width of signed(delta) * signed({1'b0, activation}) without loss.
   function automatic int unsigned prod_width(input int unsigned dw, input int unsigned aw);
      return dw + aw + 1;
   endfunction

   // Largest positive value of a w-bit two's-complement cell.
   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Most negative value of a w-bit two's-complement cell.
   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/delta_row_mult.sv
// One delta cell times the whole a_prev vector, scaled by the learning-rate
// shift and narrowed to the weight cell width (wrap, or clamp when
// WEIGHT_DELTA_SATURATE_EN is defined).
//   delta_cell_i : signed delta cell
//   a_prev_i     : unsigned activation vector, cell j at [j*AW +: AW]
//   cells_o      : signed result cells, cell j at [j*WW +: WW]
//   ovf_o        : OR of per-cell overflow
module delta_row_mult
   import backprop_pkg::*;
#(
   parameter int unsigned INPUT_NUM         = 4,
   parameter int unsigned DELTA_CELL_WIDTH  = 10,
   parameter int unsigned ACTIVATION_WIDTH  = 9,
   parameter int unsigned WEIGHT_CELL_WIDTH = 16,
   parameter int unsigned FRACTION_WIDTH    = 0,
   parameter int unsigned LR_SHIFT          = 2
) (
   input  logic [DELTA_CELL_WIDTH-1:0]            delta_cell_i,
   input  logic [INPUT_NUM*ACTIVATION_WIDTH-1:0]  a_prev_i,
   output logic [INPUT_NUM*WEIGHT_CELL_WIDTH-1:0] cells_o,
   output logic                                   ovf_o
);

   localparam int unsigned DW = DELTA_CELL_WIDTH;
   localparam int unsigned AW = ACTIVATION_WIDTH;
   localparam int unsigned WW = WEIGHT_CELL_WIDTH;
   localparam int unsigned PW = prod_width(DW, AW);
   localparam int unsigned SH = FRACTION_WIDTH + LR_SHIFT;

`ifdef WEIGHT_DELTA_SATURATE_EN
   localparam logic [WW-1:0] SAT_MAX = WW'(sat_max(WW));
   localparam logic [WW-1:0] SAT_MIN = WW'(sat_min(WW));
`endif

   logic [INPUT_NUM-1:0] ovf_vec;

   for (genvar j = 0; j < INPUT_NUM; j++) begin : g_cell
      logic [AW-1:0]        a_cell;
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] shifted;
      logic                 ovf;
      logic [WW-1:0]        wrapped;

      assign a_cell  = a_prev_i[j*AW +: AW];
      // Activation is unsigned: zero-extend by one bit before the signed multiply.
      assign prod    = PW'($signed(delta_cell_i)) * PW'($signed({1'b0, a_cell}));
      assign shifted = prod >>> SH;
      assign wrapped = WW'(shifted);

      // Fits in WW bits only if all bits from the WW-1 sign position upward agree.
      if (PW > WW) begin : g_ovf
         assign ovf = ~((&shifted[PW-1:WW-1]) | ~(|shifted[PW-1:WW-1]));
      end else begin : g_no_ovf
         assign ovf = 1'b0;
      end

`ifdef WEIGHT_DELTA_SATURATE_EN
      assign cells_o[j*WW +: WW] = ovf ? (shifted[PW-1] ? SAT_MIN : SAT_MAX) : wrapped;
`else
      assign cells_o[j*WW +: WW] = wrapped;
`endif
      assign ovf_vec[j] = ovf;
   end

   assign ovf_o = |ovf_vec;

endmodule

// File: rtl/weight_delta_generator.sv
// Builds dW[i][j] = (delta[i]*a_prev[j]) >>> (FRACTION_WIDTH+LR_SHIFT) and
// streams it one neuron row per beat toward the weight memory updater.
// Optional macro: WEIGHT_DELTA_SATURATE_EN (clamp instead of wrap on overflow).
//   clk, rst                 : clock, synchronous active-high reset
//   delta/_valid/_ready      : delta vector operand
//   a_prev/_valid/_ready     : previous-layer activation operand
//   row/_index/_last/_valid/_ready : dW row stream
//   error                    : overflow in some cell of the current row
module weight_delta_generator
   import backprop_pkg::*;
#(
   parameter int unsigned NEURON_NUM        = 5,
   parameter int unsigned INPUT_NUM         = 4,
   parameter int unsigned DELTA_CELL_WIDTH  = 10,
   parameter int unsigned ACTIVATION_WIDTH  = 9,
   parameter int unsigned WEIGHT_CELL_WIDTH = 16,
   parameter int unsigned FRACTION_WIDTH    = 0,
   parameter int unsigned LR_SHIFT          = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0] delta,
   input  logic                                   delta_valid,
   output logic                                   delta_ready,
   input  logic [INPUT_NUM*ACTIVATION_WIDTH-1:0]  a_prev,
   input  logic                                   a_prev_valid,
   output logic                                   a_prev_ready,
   output logic [INPUT_NUM*WEIGHT_CELL_WIDTH-1:0] row,
   output logic [clog2(NEURON_NUM)-1:0]           row_index,
   output logic                                   row_last,
   output logic                                   row_valid,
   input  logic                                   row_ready,
   output logic                                   error
);

   localparam int unsigned DW  = DELTA_CELL_WIDTH;
   localparam int unsigned RIW = clog2(NEURON_NUM);
   localparam int unsigned DVW = NEURON_NUM * DELTA_CELL_WIDTH;
   localparam int unsigned AVW = INPUT_NUM * ACTIVATION_WIDTH;
   localparam int unsigned RW  = INPUT_NUM * WEIGHT_CELL_WIDTH;
   localparam logic [RIW-1:0] LAST_IDX = RIW'(NEURON_NUM - 1);

   state_t state_q, state_d;

   logic           have_delta_q, have_delta_d;
   logic           have_a_q, have_a_d;
   logic [DVW-1:0] delta_q, delta_d;
   logic [AVW-1:0] a_q, a_d;
   logic [RIW-1:0] row_cnt_q, row_cnt_d;
   logic [RW-1:0]  row_q, row_d;
   logic           row_last_q, row_last_d;
   logic           row_valid_q, row_valid_d;
   logic           error_q, error_d;

   logic           delta_fire, a_fire;
   logic [RIW-1:0] next_cnt, mult_sel;
   logic [DW-1:0]  mult_delta;
   logic [RW-1:0]  mult_row;
   logic           mult_ovf;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (have_delta_q && have_a_q)   state_d = ST_LOAD;
         ST_LOAD:                                 state_d = ST_EMIT;
         ST_EMIT: if (row_ready && row_last_q)    state_d = ST_IDLE;
         default:                                 state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: operand readys, held low during reset and outside IDLE
   always_comb begin
      delta_ready  = 1'b0;
      a_prev_ready = 1'b0;
      if (!rst && state_q == ST_IDLE) begin
         delta_ready  = !have_delta_q;
         a_prev_ready = !have_a_q;
      end
   end

   assign delta_fire = delta_valid  & delta_ready;
   assign a_fire     = a_prev_valid & a_prev_ready;

   // LOAD computes row 0; EMIT precomputes the row after the current one.
   assign next_cnt = row_cnt_q + RIW'(1);
   assign mult_sel = (state_q == ST_LOAD) ? '0 : next_cnt;

   // Select the delta cell feeding the shared row multiplier
   always_comb begin
      mult_delta = '0;
      for (int i = 0; i < NEURON_NUM; i++) begin
         if (mult_sel == RIW'(i)) mult_delta = delta_q[i*DW +: DW];
      end
   end

   delta_row_mult #(
      .INPUT_NUM         (INPUT_NUM),
      .DELTA_CELL_WIDTH  (DELTA_CELL_WIDTH),
      .ACTIVATION_WIDTH  (ACTIVATION_WIDTH),
      .WEIGHT_CELL_WIDTH (WEIGHT_CELL_WIDTH),
      .FRACTION_WIDTH    (FRACTION_WIDTH),
      .LR_SHIFT          (LR_SHIFT)
   ) u_row_mult (
      .delta_cell_i (mult_delta),
      .a_prev_i     (a_q),
      .cells_o      (mult_row),
      .ovf_o        (mult_ovf)
   );

   // Operand capture, row counter and output row next-state
   always_comb begin
      have_delta_d = have_delta_q;
      have_a_d     = have_a_q;
      delta_d      = delta_q;
      a_d          = a_q;
      row_cnt_d    = row_cnt_q;
      row_d        = row_q;
      row_last_d   = row_last_q;
      row_valid_d  = row_valid_q;
      error_d      = error_q;

      case (state_q)
         ST_IDLE: begin
            if (delta_fire) begin
               delta_d      = delta;
               have_delta_d = 1'b1;
            end
            if (a_fire) begin
               a_d      = a_prev;
               have_a_d = 1'b1;
            end
            // Flags are released on the way out; operands stay in delta_q/a_q.
            if (have_delta_q && have_a_q) begin
               have_delta_d = 1'b0;
               have_a_d     = 1'b0;
               row_cnt_d    = '0;
            end
         end
         ST_LOAD: begin
            row_d       = mult_row;
            row_cnt_d   = '0;
            row_last_d  = (NEURON_NUM == 1);
            error_d     = mult_ovf;
            row_valid_d = 1'b1;
         end
         ST_EMIT: begin
            if (row_ready) begin
               if (row_last_q) begin
                  row_valid_d = 1'b0;
               end else begin
                  row_d      = mult_row;
                  row_cnt_d  = next_cnt;
                  row_last_d = (next_cnt == LAST_IDX);
                  error_d    = mult_ovf;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         have_delta_q <= 1'b0;
         have_a_q     <= 1'b0;
         delta_q      <= '0;
         a_q          <= '0;
         row_cnt_q    <= '0;
         row_q        <= '0;
         row_last_q   <= 1'b0;
         row_valid_q  <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         have_delta_q <= have_delta_d;
         have_a_q     <= have_a_d;
         delta_q      <= delta_d;
         a_q          <= a_d;
         row_cnt_q    <= row_cnt_d;
         row_q        <= row_d;
         row_last_q   <= row_last_d;
         row_valid_q  <= row_valid_d;
         error_q      <= error_d;
      end
   end

   assign row       = row_q;
   assign row_index = row_cnt_q;
   assign row_last  = row_last_q;
   assign row_valid = row_valid_q;
   assign error     = error_q;

endmodule

// File: tb/tb_weight_delta_generator.sv
// Scoreboard bench for weight_delta_generator: expected rows come from an
// integer model of dW = floor(delta*a / 2^shift) narrowed to 16 bits.
module tb_weight_delta_generator;

   localparam int N   = 5;
   localparam int IN  = 4;
   localparam int DW  = 10;
   localparam int AW  = 9;
   localparam int WW  = 16;
   localparam int SH  = 2;
   localparam int RIW = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N*DW-1:0]    delta = '0;
   logic               delta_valid = 1'b0;
   logic               delta_ready;
   logic [IN*AW-1:0]   a_prev = '0;
   logic               a_prev_valid = 1'b0;
   logic               a_prev_ready;
   logic [IN*WW-1:0]   row;
   logic [RIW-1:0]     row_index;
   logic               row_last;
   logic               row_valid;
   logic               row_ready = 1'b0;
   logic               error;

   weight_delta_generator dut (
      .clk          (clk),
      .rst          (rst),
      .delta        (delta),
      .delta_valid  (delta_valid),
      .delta_ready  (delta_ready),
      .a_prev       (a_prev),
      .a_prev_valid (a_prev_valid),
      .a_prev_ready (a_prev_ready),
      .row          (row),
      .row_index    (row_index),
      .row_last     (row_last),
      .row_valid    (row_valid),
      .row_ready    (row_ready),
      .error        (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IN*WW-1:0] row;
      logic [RIW-1:0]   idx;
      logic             last;
      logic             err;
   } exp_t;

   exp_t sb_q[$];
   int   acc_cyc[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;
   int   rdy_mode  = 0;   // 0 always ready, 1 toggle, 2 random
   int   d_arr[N];
   int   a_arr[IN];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference arithmetic: plain integer product, floor-scaled, narrowed.
   function automatic logic [WW-1:0] model_cell(input int d, input int a, output bit ovf);
      int p;
      int s;
      p   = d * a;
      s   = p >>> SH;
      ovf = (s > 32767) || (s < -32768);
`ifdef WEIGHT_DELTA_SATURATE_EN
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
`endif
      return WW'(s);
   endfunction

   task automatic push_expected();
      exp_t e;
      bit   o;
      for (int i = 0; i < N; i++) begin
         e.row = '0;
         e.err = 1'b0;
         for (int j = 0; j < IN; j++) begin
            e.row[j*WW +: WW] = model_cell(d_arr[i], a_arr[j], o);
            e.err = e.err | o;
         end
         e.idx  = RIW'(i);
         e.last = (i == N - 1);
         sb_q.push_back(e);
      end
   endtask

   function automatic logic [N*DW-1:0] pack_delta();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(d_arr[i]);
      return v;
   endfunction

   function automatic logic [IN*AW-1:0] pack_a();
      logic [IN*AW-1:0] v;
      for (int j = 0; j < IN; j++) v[j*AW +: AW] = AW'(a_arr[j]);
      return v;
   endfunction

   // Row-ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       row_ready = 1'b1;
         1:       row_ready = ~row_ready;
         default: row_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every presented row must match the scoreboard head; pop on accept.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (row_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_row_valid", 64'(row_valid), 64'd0);
         end else begin
            e = sb_q[0];
            chk("row_data",  64'(row),       64'(e.row));
            chk("row_index", 64'(row_index), 64'(e.idx));
            chk("row_last",  64'(row_last),  64'(e.last));
            chk("row_error", 64'(error),     64'(e.err));
            if (row_ready) begin
               void'(sb_q.pop_front());
               acc_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic drive_op(input bit is_delta, input logic [N*DW-1:0] dv,
                           input logic [IN*AW-1:0] av, input int gap, input bit other_pending);
      bit ok;
      ok = 1'b0;
      repeat (gap) @(posedge clk);
      @(posedge clk);
      #1;
      if (is_delta) begin delta = dv; delta_valid = 1'b1; end
      else          begin a_prev = av; a_prev_valid = 1'b1; end
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (is_delta ? delta_ready : a_prev_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("operand_handshake_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      if (is_delta) begin delta_valid = 1'b0; delta = N*DW'($urandom); end
      else          begin a_prev_valid = 1'b0; a_prev = IN*AW'($urandom); end
      @(negedge clk);
      if (is_delta) begin
         chk("delta_ready_drop", 64'(delta_ready), 64'd0);
         if (other_pending) chk("a_prev_ready_held", 64'(a_prev_ready), 64'd1);
      end else begin
         chk("a_prev_ready_drop", 64'(a_prev_ready), 64'd0);
         if (other_pending) chk("delta_ready_held", 64'(delta_ready), 64'd1);
      end
   endtask

   // order: 0 simultaneous, 1 a_prev 3 cycles first, 2 delta 3 cycles first
   task automatic issue(input int order);
      logic [N*DW-1:0]  dv;
      logic [IN*AW-1:0] av;
      push_expected();
      dv = pack_delta();
      av = pack_a();
      case (order)
         0: fork drive_op(1'b1, dv, av, 0, 1'b0); drive_op(1'b0, dv, av, 0, 1'b0); join
         1: fork drive_op(1'b0, dv, av, 0, 1'b1); drive_op(1'b1, dv, av, 3, 1'b0); join
         default: fork drive_op(1'b1, dv, av, 0, 1'b1); drive_op(1'b0, dv, av, 3, 1'b0); join
      endcase
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300; k++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_remaining_rows", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
      @(negedge clk);
   endtask

   task automatic clear_ops();
      for (int i = 0; i < N; i++)  d_arr[i] = 0;
      for (int j = 0; j < IN; j++) a_arr[j] = 0;
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1);
   end

   initial begin
      bit found;
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      // Reset state
      chk("reset_row_valid",    64'(row_valid),    64'd0);
      chk("reset_row",          64'(row),          64'd0);
      chk("reset_row_index",    64'(row_index),    64'd0);
      chk("reset_row_last",     64'(row_last),     64'd0);
      chk("reset_error",        64'(error),        64'd0);
      chk("reset_delta_ready",  64'(delta_ready),  64'd0);
      chk("reset_a_prev_ready", 64'(a_prev_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_delta_ready",  64'(delta_ready),  64'd1);
      chk("idle_a_prev_ready", 64'(a_prev_ready), 64'd1);

      // 1: uniform operands, latency and back-to-back beats
      for (int i = 0; i < N; i++)  d_arr[i] = 100;
      for (int j = 0; j < IN; j++) a_arr[j] = 8;
      acc_cyc.delete();
      issue(0);
      chk("latency_t1_valid", 64'(row_valid), 64'd0);
      @(negedge clk);
      chk("latency_t2_valid", 64'(row_valid), 64'd0);
      @(negedge clk);
      chk("latency_t3_valid", 64'(row_valid), 64'd1);
      wait_drain();
      chk("beats_accepted", 64'(acc_cyc.size()), 64'd5);
      if (acc_cyc.size() == 5)
         chk("beats_consecutive", 64'(acc_cyc[4] - acc_cyc[0]), 64'd4);

      // 2: negative products and floor rounding
      clear_ops();
      d_arr[2] = -100; a_arr[1] = 8;
      d_arr[3] = -1;   a_arr[0] = 1;
      issue(0);
      wait_drain();

      // 3: overflow in row 0 only
      clear_ops();
      d_arr[0] = 511; a_arr[0] = 511;
      d_arr[1] = 3;   a_arr[2] = 7;
      issue(0);
      wait_drain();

      // 4: operand order does not matter
      for (int i = 0; i < N; i++)  d_arr[i] = int'($urandom_range(0, 1023)) - 512;
      for (int j = 0; j < IN; j++) a_arr[j] = int'($urandom_range(0, 511));
      issue(1);
      wait_drain();
      issue(2);
      wait_drain();

      // 5: toggling row_ready holds each row until accepted
      rdy_mode = 1;
      issue(0);
      wait_drain();

      // 6: reset in the middle of a matrix
      rdy_mode = 0;
      for (int i = 0; i < N; i++)  d_arr[i] = int'($urandom_range(0, 1023)) - 512;
      for (int j = 0; j < IN; j++) a_arr[j] = int'($urandom_range(0, 511));
      issue(0);
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (row_valid && row_index == 3'd2) begin found = 1'b1; break; end
      end
      chk("reached_beat_2", 64'(found), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_row_valid",    64'(row_valid),    64'd0);
      chk("midrst_delta_ready",  64'(delta_ready),  64'd0);
      chk("midrst_a_prev_ready", 64'(a_prev_ready), 64'd0);
      sb_q.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_delta_ready",  64'(delta_ready),  64'd1);
      chk("postrst_a_prev_ready", 64'(a_prev_ready), 64'd1);
      chk("postrst_row_valid",    64'(row_valid),    64'd0);
      issue(0);
      wait_drain();

      // Randomized matrices, orders and back-pressure
      for (int r = 0; r < 10; r++) begin
         rdy_mode = int'($urandom_range(0, 2));
         for (int i = 0; i < N; i++)  d_arr[i] = int'($urandom_range(0, 1023)) - 512;
         for (int j = 0; j < IN; j++) a_arr[j] = int'($urandom_range(0, 511));
         if (r % 3 == 0) d_arr[int'($urandom_range(0, N - 1))] = -512;
         issue(int'($urandom_range(0, 2)));
         wait_drain();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
